symbol_ring_store: RTL and testbench

- Parametrised successor to the 64-QAM symbol storage stage. Buffers mapped I/Q symbols in a circular RAM between the mapper FIFO and the DAC/pulse-shaping stage.
- Adds a ready/valid drain port, a fill level, and selectable overwrite/drop behaviour on overflow.
- Keeps the host register-access path: address/write-data FIFOs in, read-data FIFO out, with a programmable read-sync wait. Sits between the symbol mapper FIFOs and the TX datapath, in the sym_clk domain.

---
 rtl/symbol_ring_store.sv | 182 ++++++++++++++++++
 tb/tb_symbol_ring_store.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/symbol_ring_store.sv
// Circular I/Q symbol buffer between the mapper FIFO and the TX datapath.
// Provides a ready/valid drain port, a fill level, and host register access through FIFOs.
module symbol_ring_store #(
  parameter  int IQ_W      = 4,
  parameter  int DEPTH     = 512,
  parameter  int ADDR_W    = 10,
  parameter  int READ_WAIT = 150,
  parameter  int WRAP_MODE = 1,
  localparam int SW        = 2 * IQ_W,
  localparam int PW        = $clog2(DEPTH)
) (
  input  logic              sym_clk,
  input  logic              rst,
  input  logic [IQ_W-1:0]   sym_i,
  input  logic [IQ_W-1:0]   sym_q,
  input  logic              new_symbol,
  input  logic              sym_fifo_empty,
  output logic              sym_fifo_rd_en,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [SW-1:0]     host_wdata,
  input  logic              host_we,
  input  logic              host_re,
  input  logic              wdata_fifo_empty,
  input  logic              rdata_fifo_full,
  output logic              wdata_fifo_rd_en,
  output logic              addr_fifo_rd_en,
  output logic              rdata_fifo_wr_en,
  output logic [SW-1:0]     host_rdata,
  output logic              host_rdata_valid,
  output logic [SW-1:0]     out_sym,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PW:0]       fill_level,
  output logic              overflow
);

  localparam int CW = (READ_WAIT < 1) ? 1 : $clog2(READ_WAIT + 1);
  localparam logic [ADDR_W-1:0] ADDR_OVF  = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_FILL = ADDR_W'(DEPTH + 1);
  localparam logic [PW:0]       FILL_MAX  = (PW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WRITE, READ, MAP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]     fill_q, fill_d;
  logic            ovf_q, ovf_d;
  logic [SW-1:0]   rdata_q, rdata_d;
  logic            rvalid_q, rvalid_d;
  logic            sym_en_q, sym_en_d, wdata_en_q, wdata_en_d;
  logic            addr_en_q, addr_en_d, rdata_en_q, rdata_en_d;

  logic [SW-1:0]   ram [DEPTH];
  logic            ram_we;
  logic [PW-1:0]   ram_waddr;
  logic [SW-1:0]   ram_wdata;

  logic            pop, full, push_ok, wrap_adv;

  assign full = (fill_q == FILL_MAX);
  assign pop  = (fill_q != '0) && out_ready;

  // NOTE: always_comb uses blocking assignments and gives every target a default first,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = wr_ptr_q;
    ram_wdata = {sym_i, sym_q};
    push_ok   = 1'b0;
    wrap_adv  = 1'b0;

    case (state_q)
      IDLE: begin
        if (new_symbol && !sym_fifo_empty)     state_d = MAP;
        else if (host_re && !rdata_fifo_full)  state_d = READ;
        else if (host_we && !wdata_fifo_empty) state_d = WRITE;
      end
      WRITE: begin
        if (host_addr < ADDR_OVF) begin
          ram_we    = 1'b1;
          ram_waddr = host_addr[PW-1:0];
          ram_wdata = host_wdata;
        end else if (host_addr == ADDR_OVF) begin
          ovf_d = 1'b0;
        end
        state_d = IDLE;
      end
      READ: begin
        if (cnt_q == '0) begin
          if (host_addr < ADDR_OVF)        rdata_d = ram[host_addr[PW-1:0]];
          else if (host_addr == ADDR_OVF)  rdata_d = SW'(ovf_q);
          else if (host_addr == ADDR_FILL) rdata_d = SW'(fill_q);
          else                             rdata_d = '0;
          rvalid_d = 1'b1;
          cnt_d    = CW'(READ_WAIT);
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      MAP: begin
        // A pop in the same cycle frees the slot, so a full buffer still takes a normal push.
        if (!full || pop) begin
          ram_we  = 1'b1;
          push_ok = 1'b1;
        end else begin
          ovf_d = 1'b1;
          if (WRAP_MODE != 0) begin
            ram_we   = 1'b1;
            wrap_adv = 1'b1;
          end
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d   = wr_ptr_q + PW'(push_ok | wrap_adv);
    rd_ptr_d   = rd_ptr_q + PW'(pop | wrap_adv);
    fill_d     = fill_q + (PW + 1)'(push_ok) - (PW + 1)'(pop);

    sym_en_d   = (state_d == MAP);
    wdata_en_d = (state_d == WRITE);
    rdata_en_d = (state_d == READ);
    addr_en_d  = (state_d == WRITE) || (state_d == READ);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge sym_clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= CW'(READ_WAIT);
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      ovf_q      <= 1'b0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      sym_en_q   <= 1'b0;
      wdata_en_q <= 1'b0;
      addr_en_q  <= 1'b0;
      rdata_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      ovf_q      <= ovf_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      sym_en_q   <= sym_en_d;
      wdata_en_q <= wdata_en_d;
      addr_en_q  <= addr_en_d;
      rdata_en_q <= rdata_en_d;
    end
  end

  // NOTE: the symbol RAM is deliberately not reset; it maps onto plain RAM and the
  // pointers/fill level alone decide which entries are meaningful.
  always_ff @(posedge sym_clk) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
  end

  assign out_valid        = (fill_q != '0);
  assign out_sym          = out_valid ? ram[rd_ptr_q] : '0;
  assign fill_level       = fill_q;
  assign overflow         = ovf_q;
  assign host_rdata       = rdata_q;
  assign host_rdata_valid = rvalid_q;
  assign sym_fifo_rd_en   = sym_en_q;
  assign wdata_fifo_rd_en = wdata_en_q;
  assign addr_fifo_rd_en  = addr_en_q;
  assign rdata_fifo_wr_en = rdata_en_q;

endmodule

// File: tb/tb_symbol_ring_store.sv
// Scoreboard bench for symbol_ring_store: an overwrite instance and a drop instance share stimulus;
// a monitor checks drained symbols and host read data against queued expectations.
module tb_symbol_ring_store;

  localparam int IQ_W = 4, DEPTH = 512, ADDR_W = 10, READ_WAIT = 150;
  localparam int SW = 2 * IQ_W, PW = $clog2(DEPTH);

  logic              sym_clk = 1'b0;
  logic              rst = 1'b1;
  logic [IQ_W-1:0]   sym_i = '0, sym_q = '0;
  logic              new_symbol = 1'b0, sym_fifo_empty = 1'b1;
  logic [ADDR_W-1:0] host_addr = '0;
  logic [SW-1:0]     host_wdata = '0;
  logic              host_we = 1'b0, host_re = 1'b0;
  logic              wdata_fifo_empty = 1'b1, rdata_fifo_full = 1'b0;
  logic              out_ready = 1'b0;

  logic            w_sym_fifo_rd_en, w_wdata_fifo_rd_en, w_addr_fifo_rd_en, w_rdata_fifo_wr_en;
  logic [SW-1:0]   w_host_rdata, w_out_sym;
  logic            w_host_rdata_valid, w_out_valid, w_overflow;
  logic [PW:0]     w_fill_level;
  logic            d_sym_fifo_rd_en, d_wdata_fifo_rd_en, d_addr_fifo_rd_en, d_rdata_fifo_wr_en;
  logic [SW-1:0]   d_host_rdata, d_out_sym;
  logic            d_host_rdata_valid, d_out_valid, d_overflow;
  logic [PW:0]     d_fill_level;

  always #5 sym_clk = ~sym_clk;

  symbol_ring_store #(.IQ_W(IQ_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .READ_WAIT(READ_WAIT), .WRAP_MODE(1)) u_wrap (
    .sym_clk(sym_clk), .rst(rst), .sym_i(sym_i), .sym_q(sym_q), .new_symbol(new_symbol),
    .sym_fifo_empty(sym_fifo_empty), .sym_fifo_rd_en(w_sym_fifo_rd_en), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_we(host_we), .host_re(host_re), .wdata_fifo_empty(wdata_fifo_empty),
    .rdata_fifo_full(rdata_fifo_full), .wdata_fifo_rd_en(w_wdata_fifo_rd_en), .addr_fifo_rd_en(w_addr_fifo_rd_en),
    .rdata_fifo_wr_en(w_rdata_fifo_wr_en), .host_rdata(w_host_rdata), .host_rdata_valid(w_host_rdata_valid),
    .out_sym(w_out_sym), .out_valid(w_out_valid), .out_ready(out_ready), .fill_level(w_fill_level),
    .overflow(w_overflow));

  symbol_ring_store #(.IQ_W(IQ_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .READ_WAIT(READ_WAIT), .WRAP_MODE(0)) u_drop (
    .sym_clk(sym_clk), .rst(rst), .sym_i(sym_i), .sym_q(sym_q), .new_symbol(new_symbol),
    .sym_fifo_empty(sym_fifo_empty), .sym_fifo_rd_en(d_sym_fifo_rd_en), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_we(host_we), .host_re(host_re), .wdata_fifo_empty(wdata_fifo_empty),
    .rdata_fifo_full(rdata_fifo_full), .wdata_fifo_rd_en(d_wdata_fifo_rd_en), .addr_fifo_rd_en(d_addr_fifo_rd_en),
    .rdata_fifo_wr_en(d_rdata_fifo_wr_en), .host_rdata(d_host_rdata), .host_rdata_valid(d_host_rdata_valid),
    .out_sym(d_out_sym), .out_valid(d_out_valid), .out_ready(out_ready), .fill_level(d_fill_level),
    .overflow(d_overflow));

  int checks = 0, failures = 0;
  int rvalid_cnt = 0, drop_map_cnt = 0;
  logic [SW-1:0] exp_w_q[$], exp_d_q[$], exp_rd_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event occurred with no expectation or bound expired", name);
  endtask

  // Monitor samples on the falling edge; stimulus changes 2 ns after the rising edge.
  always @(negedge sym_clk) begin
    if (w_out_valid && out_ready) begin
      if (exp_w_q.size() == 0) flag_fail("wrap_drain_unexpected");
      else check("wrap_drain", w_out_sym, exp_w_q.pop_front());
    end
    if (d_out_valid && out_ready) begin
      if (exp_d_q.size() == 0) flag_fail("drop_drain_unexpected");
      else check("drop_drain", d_out_sym, exp_d_q.pop_front());
    end
    if (w_host_rdata_valid) begin
      rvalid_cnt++;
      if (exp_rd_q.size() == 0) flag_fail("rdata_unexpected");
      else check("host_rdata", w_host_rdata, exp_rd_q.pop_front());
    end
    if (d_sym_fifo_rd_en) drop_map_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge sym_clk);
    #2;
  endtask

  task automatic expect_sym(input logic [SW-1:0] s);
    exp_w_q.push_back(s);
    exp_d_q.push_back(s);
  endtask

  task automatic push_sym(input logic [SW-1:0] s);
    sym_i = s[SW-1:IQ_W];
    sym_q = s[IQ_W-1:0];
    new_symbol = 1'b1;
    sym_fifo_empty = 1'b0;
    for (int n = 0; n < 10 && !w_sym_fifo_rd_en; n++) step();
    if (!w_sym_fifo_rd_en) flag_fail("push_timeout");
    new_symbol = 1'b0;
    sym_fifo_empty = 1'b1;
    step();
  endtask

  task automatic host_write(input logic [ADDR_W-1:0] a, input logic [SW-1:0] d);
    host_addr = a;
    host_wdata = d;
    host_we = 1'b1;
    wdata_fifo_empty = 1'b0;
    for (int n = 0; n < 10 && !w_wdata_fifo_rd_en; n++) step();
    if (!w_wdata_fifo_rd_en) flag_fail("write_timeout");
    host_we = 1'b0;
    wdata_fifo_empty = 1'b1;
    step();
  endtask

  task automatic host_read(input logic [ADDR_W-1:0] a, input logic [SW-1:0] exp);
    int base, n;
    exp_rd_q.push_back(exp);
    base = rvalid_cnt;
    host_addr = a;
    host_re = 1'b1;
    for (int k = 0; k < 10 && !w_rdata_fifo_wr_en; k++) step();
    host_re = 1'b0;
    n = 0;
    while (w_rdata_fifo_wr_en && n < 1000) begin
      n++;
      step();
    end
    check("read_wait_cycles", n, READ_WAIT + 1);
    step();
    step();
    check("rvalid_single_pulse", rvalid_cnt - base, 1);
  endtask

  task automatic drain(input int n);
    out_ready = 1'b1;
    repeat (n) step();
    out_ready = 1'b0;
  endtask

  initial begin
    int ord[3];
    int idx, excl, base;
    logic [SW-1:0] s;

    // Reset state
    repeat (3) step();
    check("rst_enables", {w_sym_fifo_rd_en, w_wdata_fifo_rd_en, w_addr_fifo_rd_en, w_rdata_fifo_wr_en}, 0);
    check("rst_fill", w_fill_level, 0);
    check("rst_valid", {w_out_valid, w_host_rdata_valid, w_overflow}, 0);
    check("rst_rdata", w_host_rdata, 0);
    rst = 1'b0;
    step();

    // Three pushes with downstream stalled, then drain in order
    push_sym(8'h12); push_sym(8'h34); push_sym(8'h56);
    expect_sym(8'h12); expect_sym(8'h34); expect_sym(8'h56);
    check("basic_fill", w_fill_level, 3);
    check("basic_head", w_out_sym, 8'h12);
    check("basic_valid", w_out_valid, 1);
    drain(3);
    check("basic_empty_valid", w_out_valid, 0);
    check("basic_empty_fill", w_fill_level, 0);

    // Host overwrites the entry at the read pointer while it is valid
    push_sym(8'hEE);
    check("head_before_hostwr", w_out_sym, 8'hEE);
    host_write(10'd3, 8'h4B);
    check("head_after_hostwr", w_out_sym, 8'h4B);
    expect_sym(8'h4B);
    drain(1);

    // Host write then read of a RAM location
    host_write(10'd10, 8'hA5);
    host_read(10'd10, 8'hA5);

    // Simultaneous requests: MAP, then READ, then WRITE
    expect_sym(8'h9C);
    exp_rd_q.push_back(8'h00);
    sym_i = 4'h9; sym_q = 4'hC;
    host_addr = 10'd1023; host_wdata = 8'h77;
    new_symbol = 1'b1; sym_fifo_empty = 1'b0;
    host_re = 1'b1; host_we = 1'b1; wdata_fifo_empty = 1'b0;
    idx = 0; excl = 0;
    for (int n = 0; n < 400 && idx < 3; n++) begin
      step();
      if ($countones({w_sym_fifo_rd_en, w_wdata_fifo_rd_en, w_rdata_fifo_wr_en}) > 1) excl++;
      if (w_sym_fifo_rd_en && new_symbol) begin
        ord[idx] = 1; idx++; new_symbol = 1'b0; sym_fifo_empty = 1'b1;
      end
      if (w_rdata_fifo_wr_en && host_re) begin
        ord[idx] = 2; idx++; host_re = 1'b0;
      end
      if (w_wdata_fifo_rd_en && host_we) begin
        ord[idx] = 3; idx++; host_we = 1'b0; wdata_fifo_empty = 1'b1;
      end
    end
    step();
    check("prio_served", idx, 3);
    check("prio_first_map", ord[0], 1);
    check("prio_second_read", ord[1], 2);
    check("prio_third_write", ord[2], 3);
    check("prio_exclusive", excl, 0);
    drain(1);

    // 513 pushes into a 512-deep buffer with downstream stalled
    drop_map_cnt = 0;
    for (int i = 0; i <= DEPTH; i++) begin
      s = SW'(i + 8'h30);
      push_sym(s);
      if (i >= 1) exp_w_q.push_back(s);
      if (i < DEPTH) exp_d_q.push_back(s);
    end
    check("wrap_fill", w_fill_level, DEPTH);
    check("drop_fill", d_fill_level, DEPTH);
    check("wrap_overflow", w_overflow, 1);
    check("drop_overflow", d_overflow, 1);
    check("wrap_head", w_out_sym, 8'h31);
    check("drop_head", d_out_sym, 8'h30);
    check("drop_map_pulses", drop_map_cnt, DEPTH + 1);
    drain(DEPTH);
    check("wrap_drained", w_out_valid, 0);
    check("drop_drained", d_out_valid, 0);

    // Status registers: overflow read/clear, fill level read
    host_read(10'd512, 8'h01);
    host_write(10'd512, 8'hFF);
    check("ovf_clear_wrap", w_overflow, 0);
    check("ovf_clear_drop", d_overflow, 0);
    push_sym(8'h11); push_sym(8'h22);
    expect_sym(8'h11); expect_sym(8'h22);
    host_read(10'd513, 8'h02);
    drain(2);

    // Reset in the middle of a host read
    push_sym(8'h5A);
    host_addr = 10'd10;
    host_re = 1'b1;
    for (int k = 0; k < 10 && !w_rdata_fifo_wr_en; k++) step();
    host_re = 1'b0;
    repeat (80) step();
    check("mid_read_active", w_rdata_fifo_wr_en, 1);
    base = rvalid_cnt;
    rst = 1'b1;
    #1;
    check("rst_mid_enables", {w_rdata_fifo_wr_en, w_addr_fifo_rd_en, w_sym_fifo_rd_en}, 0);
    check("rst_mid_rdata", w_host_rdata, 0);
    check("rst_mid_fill", {w_fill_level, d_fill_level}, 0);
    check("rst_mid_valid", {w_out_valid, d_out_valid, w_host_rdata_valid}, 0);
    check("rst_mid_sym", w_out_sym, 0);
    exp_w_q.delete();
    exp_d_q.delete();
    repeat (3) step();
    rst = 1'b0;
    repeat (200) step();
    check("rst_no_rvalid", rvalid_cnt - base, 0);
    host_write(10'd10, 8'h3C);
    host_read(10'd10, 8'h3C);

    check("sym_queue_wrap_empty", exp_w_q.size(), 0);
    check("sym_queue_drop_empty", exp_d_q.size(), 0);
    check("rdata_queue_empty", exp_rd_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
